instruction_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read port.
- Owns the program counter and drives the word-aligned read address to the combinational instruction memory.
- Captures the returned instruction word into the IF/ID pipeline register.
- Supports hazard freeze, taken-branch redirect with flush, and a retired-fetch counter. Sits between the hazard/branch logic and the decode stage.

---
 rtl/instruction_fetch_unit.sv | 53 +++++
 tb/tb_instruction_fetch_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory read address,
// and captures the returned word into the IF/ID register with freeze and branch-flush.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_addr,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  output logic [31:0]          pc_out,
  output logic [31:0]          instruction,
  output logic                 valid,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        vld;
  } ifid_t;

  // Only the word index is stored, so the address low bits are zero by construction.
  logic [29:0] pc_word;
  ifid_t       ifid;

  assign imem_addr   = {pc_word, 2'b00};
  assign pc_out      = ifid.pc4;
  assign instruction = ifid.instr;
  assign valid       = ifid.vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_word     <= RESET_PC[31:2];
      ifid        <= '0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      // Redirect wins over freeze; the wrong-path word on imem_data is dropped.
      pc_word     <= branch_addr[31:2];
      ifid        <= '0;
    end else if (!freeze) begin
      pc_word     <= pc_word + 30'd1;
      ifid.pc4    <= {pc_word + 30'd1, 2'b00};
      ifid.instr  <= imem_data;
      ifid.vld    <= 1'b1;
      fetch_count <= fetch_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, async-reset sequences,
// wrap-around instance, and randomized run against a behavioural model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze, branch_taken;
  logic [31:0] branch_addr;
  logic [31:0] imem_addr, imem_data, pc_out, instruction;
  logic        valid;
  logic [31:0] fetch_count;

  // Second instance: wrapping reset PC, narrow counter, always running.
  logic [31:0] imem_addr2, imem_data2, pc_out2, instruction2;
  logic        valid2;
  logic [2:0]  fetch_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    if (idx == 0) return 32'h8001_060A;
    if (idx == 1) return 32'h0401_1000;
    return 32'h1000_0000 + idx;
  endfunction

  always_comb imem_data  = mem_word(imem_addr);
  always_comb imem_data2 = mem_word(imem_addr2);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc_out(pc_out), .instruction(instruction), .valid(valid),
    .fetch_count(fetch_count));

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_WIDTH(3)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0),
    .branch_addr(32'h0), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .pc_out(pc_out2), .instruction(instruction2), .valid(valid2),
    .fetch_count(fetch_count2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_ins, input logic [31:0] e_pco,
                         input logic e_v, input logic [31:0] e_cnt, input logic [31:0] e_addr);
    chk({tag, ".instruction"}, instruction, e_ins);
    chk({tag, ".pc_out"},      pc_out,      e_pco);
    chk({tag, ".valid"},       {31'b0, valid}, {31'b0, e_v});
    chk({tag, ".fetch_count"}, fetch_count, e_cnt);
    chk({tag, ".imem_addr"},   imem_addr,   e_addr);
  endtask

  typedef struct {
    logic        fz;
    logic        br;
    logic [31:0] ba;
    logic [31:0] e_ins;
    logic [31:0] e_pco;
    logic        e_v;
    logic [31:0] e_cnt;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[12];
  logic [31:0] wrap_exp[4];

  // Behavioural model state for the randomized phase
  logic [31:0] m_pc, m_ins, m_pco, m_cnt;
  logic        m_v;

  initial begin
    vecs[0]  = '{0, 0, 32'h0,  32'h8001_060A, 32'h4,  1, 1, 32'h4};
    vecs[1]  = '{0, 0, 32'h0,  32'h0401_1000, 32'h8,  1, 2, 32'h8};
    vecs[2]  = '{1, 0, 32'h0,  32'h0401_1000, 32'h8,  1, 2, 32'h8};
    vecs[3]  = '{1, 0, 32'h0,  32'h0401_1000, 32'h8,  1, 2, 32'h8};
    vecs[4]  = '{1, 0, 32'h0,  32'h0401_1000, 32'h8,  1, 2, 32'h8};
    vecs[5]  = '{0, 0, 32'h0,  32'h1000_0002, 32'hC,  1, 3, 32'hC};
    vecs[6]  = '{0, 1, 32'h16, 32'h0,         32'h0,  0, 3, 32'h14};
    vecs[7]  = '{0, 0, 32'h0,  32'h1000_0005, 32'h18, 1, 4, 32'h18};
    vecs[8]  = '{1, 1, 32'h43, 32'h0,         32'h0,  0, 4, 32'h40};
    vecs[9]  = '{0, 1, 32'h21, 32'h0,         32'h0,  0, 4, 32'h20};
    vecs[10] = '{1, 0, 32'h0,  32'h0,         32'h0,  0, 4, 32'h20};
    vecs[11] = '{0, 0, 32'h0,  32'h1000_0008, 32'h24, 1, 5, 32'h24};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    #12;
    chk_all("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    chk("reset.wrap_addr", imem_addr2, wrap_exp[0]);
    @(negedge clk); rst = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      freeze = vecs[i].fz; branch_taken = vecs[i].br; branch_addr = vecs[i].ba;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_ins, vecs[i].e_pco, vecs[i].e_v,
              vecs[i].e_cnt, vecs[i].e_addr);
      if (i < 3) chk($sformatf("wrap_addr%0d", i + 1), imem_addr2, wrap_exp[i + 1]);
      if (i == 1) chk("wrap_pc_out", pc_out2, 32'h0);
      if (i == 7) chk("wrap_count", {29'b0, fetch_count2}, 32'h0);
    end

    // Async reset mid-freeze
    freeze = 1'b1; branch_taken = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0; #1;
    chk_all("rst_freeze", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1 rst = 1'b1; freeze = 1'b0;
    @(posedge clk); #1;
    chk_all("post_rst", 32'h8001_060A, 32'h4, 1'b1, 32'h1, 32'h4);

    // Async reset mid-branch
    branch_taken = 1'b1; branch_addr = 32'h100;
    @(posedge clk); #1;
    chk("branch_addr_pre", imem_addr, 32'h100);
    #2 rst = 1'b0; #1;
    chk_all("rst_branch", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    #1 rst = 1'b1; branch_taken = 1'b0;

    // Randomized against the model
    @(posedge clk); #1;
    m_pc = 32'h4; m_ins = 32'h8001_060A; m_pco = 32'h4; m_v = 1'b1; m_cnt = 32'h1;
    chk_all("rand_start", m_ins, m_pco, m_v, m_cnt, m_pc);
    for (int n = 0; n < 400; n++) begin
      branch_taken = ($urandom_range(0, 99) < 15);
      freeze       = ($urandom_range(0, 99) < 25);
      branch_addr  = $urandom_range(0, 255) | ($urandom_range(0, 3) == 0 ? 32'hFFFF_FF00 : 32'h0);
      if (branch_taken) begin
        m_pc = branch_addr & ~32'h3; m_ins = 32'h0; m_pco = 32'h0; m_v = 1'b0;
      end else if (!freeze) begin
        m_ins = mem_word(m_pc); m_pco = m_pc + 32'h4; m_v = 1'b1;
        m_cnt = m_cnt + 32'h1; m_pc = m_pc + 32'h4;
      end
      @(posedge clk); #1;
      chk_all($sformatf("rand%0d", n), m_ins, m_pco, m_v, m_cnt, m_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
